// File: rtl/s2p.sv
// Serial-to-parallel receiver: assembles a 1..16 bit MSB-first frame into a
// left-aligned 16-bit word, pulsing done on completion and abort when enable drops.
module s2p #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             valid,
    input  logic             enable,
    input  logic [3:0]       len,
    output logic [WIDTH-1:0] data_out,
    output logic             done,
    output logic             busy,
    output logic             abort
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [4:0]       count, count_n;
    logic [4:0]       len_q, len_n;
    logic [WIDTH-1:0] shift, shift_n;
    logic [WIDTH-1:0] data_n;
    logic             done_n, abort_n;

    logic             accept;
    logic [4:0]       eff_len;
    logic [4:0]       count_inc;
    logic [WIDTH-1:0] first_bit;

    assign accept    = enable & valid;
    assign eff_len   = (len == 4'd0) ? 5'd16 : {1'b0, len};
    assign count_inc = count + 5'd1;
    assign first_bit = {data_in, {(WIDTH-1){1'b0}}};
    assign busy      = (state == RECV);

    // Shift register only ever holds bits of the current frame (cleared on the
    // first bit), so the unused LSBs of a completed word are already zero.
    always_comb begin
        state_n = state;
        count_n = count;
        len_n   = len_q;
        shift_n = shift;
        data_n  = data_out;
        done_n  = 1'b0;
        abort_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    shift_n = first_bit;
                    len_n   = eff_len;
                    if (eff_len == 5'd1) begin
                        data_n  = first_bit;
                        done_n  = 1'b1;
                        count_n = 5'd0;
                    end else begin
                        count_n = 5'd1;
                        state_n = RECV;
                    end
                end
            end
            RECV: begin
                if (!enable) begin
                    abort_n = 1'b1;
                    count_n = 5'd0;
                    state_n = IDLE;
                end else if (valid) begin
                    shift_n = shift | (first_bit >> count);
                    count_n = count_inc;
                    if (count_inc == len_q) begin
                        data_n  = shift_n;
                        done_n  = 1'b1;
                        count_n = 5'd0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= 5'd0;
            len_q    <= 5'd0;
            shift    <= '0;
            data_out <= '0;
            done     <= 1'b0;
            abort    <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            len_q    <= len_n;
            shift    <= shift_n;
            data_out <= data_n;
            done     <= done_n;
            abort    <= abort_n;
        end
    end

endmodule

// File: tb/tb_s2p.sv
// Directed bench for s2p: short, full, gapped, aborted, reset-interrupted and
// back-to-back frames against hand-computed words.
module tb_s2p;

    logic        clk;
    logic        reset;
    logic        data_in;
    logic        valid;
    logic        enable;
    logic [3:0]  len;
    logic [15:0] data_out;
    logic        done;
    logic        busy;
    logic        abort;

    int checks   = 0;
    int failures = 0;

    s2p #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .valid    (valid),
        .enable   (enable),
        .len      (len),
        .data_out (data_out),
        .done     (done),
        .busy     (busy),
        .abort    (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        valid   = 1'b1;
        enable  = 1'b1;
        step();
        valid   = 1'b0;
    endtask

    task automatic check_ctl(input string tag, input logic d, input logic b, input logic a);
        check({tag, "_done"},  {15'd0, done},  {15'd0, d});
        check({tag, "_busy"},  {15'd0, busy},  {15'd0, b});
        check({tag, "_abort"}, {15'd0, abort}, {15'd0, a});
    endtask

    logic [15:0] word;

    initial begin
        reset = 1'b0; data_in = 1'b0; valid = 1'b0; enable = 1'b0; len = 4'd0;
        step();
        step();
        check("rst_data", data_out, 16'h0000);
        check_ctl("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        check_ctl("idle_en0", 1'b0, 1'b0, 1'b0);

        // short frame len=3, bits 1,0,1
        len = 4'd3;
        send_bit(1'b1);
        check_ctl("short_b1", 1'b0, 1'b1, 1'b0);
        send_bit(1'b0);
        check_ctl("short_b2", 1'b0, 1'b1, 1'b0);
        send_bit(1'b1);
        check_ctl("short_b3", 1'b1, 1'b0, 1'b0);
        check("short_data", data_out, 16'hA000);
        step();
        check_ctl("short_after", 1'b0, 1'b0, 1'b0);
        check("short_hold", data_out, 16'hA000);

        // full frame len=0 -> 16 bits of BEEF
        len  = 4'd0;
        word = 16'hBEEF;
        for (int i = 15; i >= 1; i--) begin
            send_bit(word[i]);
            check("full_nodone", {15'd0, done}, 16'd0);
        end
        send_bit(word[0]);
        check_ctl("full_end", 1'b1, 1'b0, 1'b0);
        check("full_data", data_out, 16'hBEEF);

        // gapped frame len=4, bits 1,1,0,1, len changed mid-frame
        len = 4'd4;
        send_bit(1'b1);
        len = 4'd2;
        step();
        check_ctl("gap_wait", 1'b0, 1'b1, 1'b0);
        send_bit(1'b1);
        check_ctl("gap_b2", 1'b0, 1'b1, 1'b0);
        step();
        send_bit(1'b0);
        check_ctl("gap_b3", 1'b0, 1'b1, 1'b0);
        step();
        step();
        send_bit(1'b1);
        check_ctl("gap_b4", 1'b1, 1'b0, 1'b0);
        check("gap_data", data_out, 16'hD000);

        // abort: len=8, 5 bits then enable low
        len = 4'd8;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        enable = 1'b0;
        step();
        check_ctl("abort_edge", 1'b0, 1'b0, 1'b1);
        check("abort_data", data_out, 16'hD000);
        step();
        check_ctl("abort_after", 1'b0, 1'b0, 1'b0);
        word = 16'h005A;
        for (int i = 7; i >= 1; i--) begin
            send_bit(word[i]);
            check("a5a_nodone", {15'd0, done}, 16'd0);
        end
        send_bit(word[0]);
        check_ctl("a5a_end", 1'b1, 1'b0, 1'b0);
        check("a5a_data", data_out, 16'h5A00);

        // reset mid-frame
        len = 4'd8;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        enable = 1'b0;
        reset  = 1'b0;
        step();
        check("mrst_data", data_out, 16'h0000);
        check_ctl("mrst", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        check_ctl("mrst_after", 1'b0, 1'b0, 1'b0);
        len = 4'd1;
        send_bit(1'b1);
        check_ctl("len1", 1'b1, 1'b0, 1'b0);
        check("len1_data", data_out, 16'h8000);

        // back-to-back len=2 frames 10 then 01
        len = 4'd2;
        send_bit(1'b1);
        check_ctl("b2b_a1", 1'b0, 1'b1, 1'b0);
        send_bit(1'b0);
        check_ctl("b2b_a2", 1'b1, 1'b0, 1'b0);
        check("b2b_data_a", data_out, 16'h8000);
        send_bit(1'b0);
        check_ctl("b2b_b1", 1'b0, 1'b1, 1'b0);
        check("b2b_hold", data_out, 16'h8000);
        send_bit(1'b1);
        check_ctl("b2b_b2", 1'b1, 1'b0, 1'b0);
        check("b2b_data_b", data_out, 16'h4000);
        enable = 1'b0;
        step();
        check_ctl("final", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
